pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core. It holds the program counter and drives the instruction-memory address. It forms PC+4 with a combinational 32-bit adder and selects the next PC from sequential, branch and jump sources. It also owns the IF/ID pipeline register that feeds decode, with stall, bubble and flush control.

Parameters:
N, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, redirect address for misaligned targets (used only with optional feature)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
stall  input  1  hazard-unit stall; hold PC and IF/ID
branch_taken  input  1  branch resolved taken (from EX)
branch_target  input  N  branch destination
jump  input  1  jump decoded (from ID)
jump_target  input  N  jump destination
imem_valid  input  1  imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
imem_addr  output  N  equals pc (combinational)
pc  output  N  current PC register
if_id_instr  output  32  IF/ID instruction
if_id_pc4  output  N  IF/ID PC+4
if_id_valid  output  1  IF/ID slot holds a real instruction
misalign_exc  output  1  one-cycle misaligned-target pulse (feature only; tied 0 otherwise)
bad_addr  output  N  offending target (feature only; tied 0 otherwise)

Behaviour:
- All state updates occur on posedge clk. rst is synchronous and active-high. rst has priority over every other input.
- Reset values: pc=RESET_PC, if_id_instr=0 (NOP), if_id_pc4=0, if_id_valid=0, misalign_exc=0, bad_addr=0.
- pc4 = pc + 4, computed modulo 2^N. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Redirect: redirect = branch_taken | jump. The target is branch_target if branch_taken=1, else jump_target. Branch wins when both are asserted, because it belongs to the older instruction.
- Redirect target bits[1:0] are forced to 0 in the PC (without the feature).
- PC next-state priority:
  1. rst
  2. redirect → target
  3. stall or !imem_valid → hold
  4. otherwise → pc4
- Redirect overrides stall.
- IF/ID next-state priority:
  1. rst
  2. redirect → flush: valid=0, instr=0, pc4=0
  3. stall → hold all three fields
  4. !imem_valid → bubble: valid=0, instr=0, pc4 holds
  5. otherwise → capture imem_rdata and pc4, valid=1
- Latency: one cycle from imem_valid to if_id_valid. The redirect target appears on pc the cycle after redirect is asserted. The wrong-path instruction fetched in the redirect cycle is discarded.
- With stall held for k cycles, pc and IF/ID are frozen exactly k cycles. No instruction is lost or duplicated.
- rst asserted mid-stream takes effect next edge regardless of stall or redirect.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - A redirect with target[1:0]≠0 loads pc=EXC_VECTOR instead of the target.
  - misalign_exc=1 for exactly one cycle and bad_addr=unmasked target; bad_addr holds until the next misalignment or rst.
  - IF/ID is flushed as for a normal redirect.
  - Aligned targets behave identically to the undefined case.
- Undefined: low bits are masked, misalign_exc and bad_addr are constant 0, and no check logic is generated.

Test Plan:
- Reset then sequential fetch: rst 1 cycle, imem_valid=1 → pc 0,4,8,C; if_id_pc4 = 4,8,C one cycle behind; if_id_valid=1 from cycle 2.
- Stall: stall=1 for 3 cycles at pc=8 → pc stays 8 and IF/ID unchanged for 3 cycles; pc=C after release.
- imem miss: imem_valid=0 for 2 cycles at pc=10 → pc holds 10; if_id_valid=0 and instr=0 for 2 cycles; then captures normally.
- Simultaneous redirect: branch_taken=1 (target=100), jump=1 (target=200) and stall=1 in the same cycle → next pc=100, if_id_valid=0, then 104.
- Wrap-around: pc=FFFF_FFFC, no stall → next pc=0000_0000, if_id_pc4=0.
- Feature on: jump_target=0000_0102 → pc=8000_0180, misalign_exc pulses 1 cycle, bad_addr=0000_0102. Feature off: same stimulus gives pc=0000_0100.

Source files
------------

// File: rtl/pc_fetch_stage_if.sv
// rtl/pc_fetch_stage_if.sv - fetch-stage bus: redirect inputs, imem port and IF/ID outputs
interface pc_fetch_stage_if #(
    parameter int N = 32
);
    logic         stall;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic         jump;
    logic [N-1:0] jump_target;
    logic         imem_valid;
    logic [31:0]  imem_rdata;
    logic [N-1:0] imem_addr;
    logic [N-1:0] pc;
    logic [31:0]  if_id_instr;
    logic [N-1:0] if_id_pc4;
    logic         if_id_valid;
    logic         misalign_exc;
    logic [N-1:0] bad_addr;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target,
               imem_valid, imem_rdata,
        output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
               misalign_exc, bad_addr
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target,
               imem_valid, imem_rdata,
        input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
               misalign_exc, bad_addr
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - MIPS instruction fetch: PC register, next-PC select, IF/ID register
// Optional misaligned-target trap enabled with `define PC_ALIGN_CHECK_EN.
module pc_fetch_stage #(
    parameter int          N          = 32,
    parameter logic [N-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [N-1:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_stage_if.master  bus
);
    logic [N-1:0] pc_q;
    logic [N-1:0] pc4;
    logic         redirect;
    logic [N-1:0] target_raw;
    logic [N-1:0] redirect_pc;
    logic [31:0]  instr_q;
    logic [N-1:0] pc4_q;
    logic         valid_q;

    assign pc4        = pc_q + N'(4);
    assign redirect   = bus.branch_taken | bus.jump;
    // Branch comes from the older instruction in EX, so it beats a jump in ID.
    assign target_raw = bus.branch_taken ? bus.branch_target : bus.jump_target;

`ifdef PC_ALIGN_CHECK_EN
    logic         misaligned;
    logic         exc_q;
    logic [N-1:0] bad_q;

    assign misaligned  = redirect & (target_raw[1:0] != 2'b00);
    assign redirect_pc = misaligned ? EXC_VECTOR : target_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_q <= 1'b0;
            bad_q <= '0;
        end else begin
            exc_q <= misaligned;
            if (misaligned)
                bad_q <= target_raw;
        end
    end

    assign bus.misalign_exc = exc_q;
    assign bus.bad_addr     = bad_q;
`else
    logic unused_exc_vector;

    assign unused_exc_vector = ^EXC_VECTOR;
    assign redirect_pc       = target_raw & ~N'(3);
    assign bus.misalign_exc  = 1'b0;
    assign bus.bad_addr      = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else if (redirect)
            pc_q <= redirect_pc;
        else if (!bus.stall && bus.imem_valid)
            pc_q <= pc4;
    end

    // The instruction fetched during a redirect is wrong-path and is dropped here.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.stall) begin
            instr_q <= instr_q;
            pc4_q   <= pc4_q;
            valid_q <= valid_q;
        end else if (!bus.imem_valid) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= bus.imem_rdata;
            pc4_q   <= pc4;
            valid_q <= 1'b1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed and random checks of pc_fetch_stage against a cycle model
module tb_pc_fetch_stage;
    localparam logic [31:0] EXC = 32'h8000_0180;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_pc, m_instr, m_pc4, m_bad;
    logic        m_valid, m_exc;

    pc_fetch_stage_if #(.N(32)) bus();

    pc_fetch_stage #(.N(32), .RESET_PC(32'h0), .EXC_VECTOR(EXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = bus.branch_taken ? bus.branch_target : bus.jump_target;
        if (rst) begin
            m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_exc = 0; m_bad = 0;
        end else begin
            m_exc = 0;
            if (bus.branch_taken || bus.jump) begin
`ifdef PC_ALIGN_CHECK_EN
                if (tgt % 4 != 0) begin
                    m_pc = EXC; m_exc = 1; m_bad = tgt;
                end else
                    m_pc = tgt;
`else
                m_pc = tgt - (tgt % 4);
`endif
                m_valid = 0; m_instr = 0; m_pc4 = 0;
            end else if (bus.stall) begin
                // everything frozen
            end else if (!bus.imem_valid) begin
                m_valid = 0; m_instr = 0;
            end else begin
                m_instr = bus.imem_rdata;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        check("pc", bus.pc, m_pc);
        check("imem_addr", bus.imem_addr, m_pc);
        check("if_id_instr", bus.if_id_instr, m_instr);
        check("if_id_pc4", bus.if_id_pc4, m_pc4);
        check("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
        check("misalign_exc", 32'(bus.misalign_exc), 32'(m_exc));
        check("bad_addr", bus.bad_addr, m_bad);
    endtask

    task automatic cycle(input logic r, input logic s, input logic bt, input logic [31:0] btg,
                         input logic j, input logic [31:0] jtg, input logic iv);
        rst               = r;
        bus.stall         = s;
        bus.branch_taken  = bt;
        bus.branch_target = btg;
        bus.jump          = j;
        bus.jump_target   = jtg;
        bus.imem_valid    = iv;
        bus.imem_rdata    = $urandom;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] t;
        logic [31:0] snap_instr;
        rst = 1'b1;
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
        bus.jump = 0; bus.jump_target = 0; bus.imem_valid = 0; bus.imem_rdata = 0;

        cycle(1, 0, 0, 0, 0, 0, 1);
        check("reset_pc", bus.pc, 32'h0);
        check("reset_valid", 32'(bus.if_id_valid), 32'h0);

        seq(2);
        check("seq_pc", bus.pc, 32'h8);
        check("seq_pc4", bus.if_id_pc4, 32'h8);
        check("seq_valid", 32'(bus.if_id_valid), 32'h1);

        snap_instr = bus.if_id_instr;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 1);
            check("stall_pc", bus.pc, 32'h8);
            check("stall_instr", bus.if_id_instr, snap_instr);
        end
        seq(1);
        check("release_pc", bus.pc, 32'hC);
        seq(1);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            check("miss_pc", bus.pc, 32'h10);
            check("miss_instr", bus.if_id_instr, 32'h0);
        end
        seq(1);
        check("after_miss_pc", bus.pc, 32'h14);

        cycle(0, 1, 1, 32'h100, 1, 32'h200, 1);
        check("redir_pc", bus.pc, 32'h100);
        check("redir_valid", 32'(bus.if_id_valid), 32'h0);
        seq(1);
        check("redir_next_pc", bus.pc, 32'h104);

        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        seq(1);
        check("wrap_pc", bus.pc, 32'h0);
        check("wrap_pc4", bus.if_id_pc4, 32'h0);

        cycle(0, 0, 0, 0, 1, 32'h0000_0102, 1);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pc", bus.pc, EXC);
        check("mis_exc", 32'(bus.misalign_exc), 32'h1);
        check("mis_bad", bus.bad_addr, 32'h102);
        seq(1);
        check("mis_pulse_end", 32'(bus.misalign_exc), 32'h0);
        check("mis_bad_hold", bus.bad_addr, 32'h102);
`else
        check("mask_pc", bus.pc, 32'h100);
        check("mask_exc", 32'(bus.misalign_exc), 32'h0);
        check("mask_bad", bus.bad_addr, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            t = $urandom;
            if ($urandom_range(0, 3) != 0)
                t[1:0] = 2'b00;
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0), t,
                  ($urandom_range(0, 9) == 0), $urandom,
                  ($urandom_range(0, 4) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
